// File: rtl/fast_corner_tx_pkg.sv
// Shared definitions for the FAST transmit path: field widths, the word
// layout of corner/trailer words, and the FIFO entry type.
package fast_pkg;

  localparam int COORD_W     = 10;
  localparam int SCORE_W     = 8;
  localparam int CNT_W       = 20;
  localparam int WORD_W      = 32;
  localparam logic [7:0] TRAILER_TAG = 8'hFF;

  // Field offsets inside a 32-bit output word
  localparam int Y_LSB     = 0;
  localparam int X_LSB     = 10;
  localparam int CNT_LSB   = 0;
  localparam int PAD_LSB   = 20;
  localparam int SCORE_LSB = 24;
  localparam int TAG_LSB   = 24;

  typedef struct packed {
    logic              is_trailer;
    logic [WORD_W-1:0] word;
  } fifo_entry_t;

  function automatic logic [WORD_W-1:0] pack_corner(input logic [SCORE_W-1:0] score,
                                                    input logic [COORD_W-1:0] x,
                                                    input logic [COORD_W-1:0] y);
    logic [WORD_W-1:0] w;
    w                        = '0;
    w[SCORE_LSB +: SCORE_W]  = score;
    w[X_LSB +: COORD_W]      = x;
    w[Y_LSB +: COORD_W]      = y;
    return w;
  endfunction

  function automatic logic [WORD_W-1:0] pack_trailer(input logic [CNT_W-1:0] cnt);
    logic [WORD_W-1:0] w;
    w                   = '0;
    w[TAG_LSB +: 8]     = TRAILER_TAG;
    w[PAD_LSB +: 4]     = 4'hF;
    w[CNT_LSB +: CNT_W] = cnt;
    return w;
  endfunction

endpackage

// File: rtl/fast_corner_tx_if.sv
// Valid/ready word stream carrying corner and trailer words toward the DMA.
interface fast_corner_tx_if;
  logic [fast_pkg::WORD_W-1:0] m_tdata;
  logic                        m_tvalid;
  logic                        m_tready;
  logic                        m_tlast;

  modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
  modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);
endinterface

// File: rtl/fast_result_fifo.sv
// Synchronous FIFO of {is_trailer, word} entries. Pointers carry one extra
// bit so full and empty are distinguishable; a write into a full FIFO is
// accepted when a read happens in the same cycle.
module fast_result_fifo
  import fast_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  fifo_entry_t wr_data,
  input  logic        rd_en,
  output fifo_entry_t rd_data,
  output logic        empty,
  output logic [AW:0] free_cnt
);

  localparam logic [AW:0] DEPTH_V = (AW+1)'(FIFO_DEPTH);

  fifo_entry_t mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] used;
  logic        full;
  logic        rd_ok;
  logic        wr_ok;

  assign used     = wr_ptr - rd_ptr;
  assign empty    = (used == '0);
  assign full     = (used == DEPTH_V);
  assign free_cnt = DEPTH_V - used;
  assign rd_ok    = rd_en & ~empty;
  assign wr_ok    = wr_en & (~full | rd_ok);
  assign rd_data  = mem[rd_ptr[AW-1:0]];

  // Storage array: data only, never reset
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Read/write pointers wrap naturally modulo 2*FIFO_DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fast_corner_tx.sv
// Transmit end of the FAST pipeline: captures scored corners into a FIFO,
// closes every frame with a trailer carrying the accepted-corner count, and
// streams words out through a single output register.
module fast_corner_tx #(
  parameter int FIFO_DEPTH = 64,
  parameter int COORD_W    = 10,
  parameter int SCORE_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 corner_vld,
  input  logic [2*COORD_W-1:0] corner_xy,
  input  logic [SCORE_W-1:0]   corner_score,
  input  logic                 frame_done,
  fast_corner_tx_if.master     m_axis,
  output logic [15:0]          overflow_cnt,
  output logic                 busy
);

  import fast_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = AW + 2;
  localparam logic [TW-1:0] DEPTH_T = TW'(FIFO_DEPTH);
  localparam int PCW = fast_pkg::COORD_W;
  localparam int PSW = fast_pkg::SCORE_W;

  logic [CNT_W-1:0] frame_cnt;
  logic             trailer_pend;

  fifo_entry_t fifo_wdata;
  fifo_entry_t fifo_rdata;
  logic        fifo_wr;
  logic        fifo_rd;
  logic        fifo_empty;
  logic [AW:0] fifo_free;

  logic [TW-1:0] held;
  logic [TW-1:0] room;
  logic          pend_now;
  logic          corner_wr;
  logic          corner_drop;
  logic          trailer_wr;

  logic [PCW-1:0] cx;
  logic [PCW-1:0] cy;
  logic [PSW-1:0] cs;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign cx = PCW'(corner_xy[2*COORD_W-1:COORD_W]);
  assign cy = PCW'(corner_xy[COORD_W-1:0]);
  assign cs = PSW'(corner_score);

  // The output register counts as one of the FIFO_DEPTH slots, so the total
  // number of words buffered in the block never exceeds FIFO_DEPTH and the
  // last free slot is kept for the frame trailer.
  assign held = (DEPTH_T - TW'(fifo_free)) + TW'(m_axis.m_tvalid);
  assign room = DEPTH_T - held;

  assign fifo_rd     = ~fifo_empty & (~m_axis.m_tvalid | m_axis.m_tready);
  assign corner_wr   = ce & corner_vld & (room >= TW'(2));
  assign corner_drop = ce & corner_vld & ~(room >= TW'(2));
  assign pend_now    = trailer_pend | (ce & frame_done);
  assign trailer_wr  = pend_now & ~corner_wr & (room != '0);
  assign fifo_wr     = corner_wr | trailer_wr;

  assign busy = ~fifo_empty | m_axis.m_tvalid | trailer_pend;

  // Select the entry written this cycle: trailer wins only when no corner is written
  always_comb begin
    fifo_wdata = '0;
    if (trailer_wr) begin
      fifo_wdata.is_trailer = 1'b1;
      fifo_wdata.word       = pack_trailer(frame_cnt);
    end else begin
      fifo_wdata.is_trailer = 1'b0;
      fifo_wdata.word       = pack_corner(cs, cx, cy);
    end
  end

  // Frame corner count, pending-trailer flag and saturating drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt    <= '0;
      trailer_pend <= 1'b0;
      overflow_cnt <= '0;
    end else begin
      if (trailer_wr)     frame_cnt <= '0;
      else if (corner_wr) frame_cnt <= sat_inc_cnt(frame_cnt);
      trailer_pend <= pend_now & ~trailer_wr;
      if (corner_drop) overflow_cnt <= sat_inc16(overflow_cnt);
    end
  end

  // Output register: reload on a transfer or when empty, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis.m_tdata  <= '0;
      m_axis.m_tlast  <= 1'b0;
      m_axis.m_tvalid <= 1'b0;
    end else if (fifo_rd) begin
      m_axis.m_tdata  <= fifo_rdata.word;
      m_axis.m_tlast  <= fifo_rdata.is_trailer;
      m_axis.m_tvalid <= 1'b1;
    end else if (m_axis.m_tready) begin
      m_axis.m_tvalid <= 1'b0;
    end
  end

  fast_result_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (fifo_wr),
    .wr_data  (fifo_wdata),
    .rd_en    (fifo_rd),
    .rd_data  (fifo_rdata),
    .empty    (fifo_empty),
    .free_cnt (fifo_free)
  );

endmodule
